// File: rtl/corelet_ctrl.sv
// Tile sequencer for the corelet datapath: fetches operands from xmem, drives the array
// instruction and strobes, then drains OFIFO through the SFP with a 3-stage pmem read-modify-write.
module corelet_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_sel,
  input  logic              acc_sel,
  input  logic [len_w-1:0]  num_vec,
  input  logic [addr_w-1:0] w_base,
  input  logic [addr_w-1:0] a_base,
  input  logic [addr_w-1:0] p_base,
  input  logic              ofifo_valid,
  output logic              busy,
  output logic              done,
  output logic              xmem_cen,
  output logic [addr_w-1:0] xmem_addr,
  output logic              pmem_rd,
  output logic [addr_w-1:0] pmem_rd_addr,
  output logic              pmem_wr,
  output logic [addr_w-1:0] pmem_wr_addr,
  output logic [2:0]        inst_w,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic              ififo_wr,
  output logic              ififo_rd,
  output logic              sfp_acc_en,
  output logic              ofifo_rd
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_FETCH, S_W_LOAD, S_W_SETTLE, S_A_FETCH, S_I_FETCH,
    S_EXEC, S_FLUSH, S_DRAIN, S_ACC, S_DONE
  } state_t;

  localparam logic [len_w-1:0] L_COL_M1 = len_w'(col - 1);
  localparam logic [len_w-1:0] L_RC_M1  = len_w'(row + col - 1);

  state_t            r_state, w_nxt;
  logic [len_w-1:0]  r_cnt, r_num, r_icnt, r_wcnt;
  logic              r_mode, r_acc, r_iss_all, r_v0;
  logic [addr_w-1:0] r_w_base, r_a_base, r_p_base, r_a1;
  logic              r_xmem_cen, r_l0_wr, r_ififo_wr, r_l0_rd, r_ififo_rd;
  logic              r_busy, r_done, r_pmem_rd, r_pmem_wr, r_ofifo_rd, r_sfp;
  logic [addr_w-1:0] r_xmem_addr, r_rd_addr, r_wr_addr;
  logic [2:0]        r_inst;

  logic [len_w-1:0]  w_n_m1, w_lim;
  logic              w_fetch, w_nxt_fetch, w_timed, w_issue;
  logic [addr_w-1:0] w_w_src, w_a_src;

  function automatic logic [2:0] f_inst(input state_t s, input logic os);
    case (s)
      S_W_LOAD: f_inst = 3'b001;
      S_EXEC:   f_inst = os ? 3'b110 : 3'b010;
      S_FLUSH:  f_inst = 3'b101;
      default:  f_inst = 3'b000;
    endcase
  endfunction

  assign w_n_m1      = r_num - 1'b1;
  assign w_fetch     = (r_state == S_W_FETCH) || (r_state == S_A_FETCH) || (r_state == S_I_FETCH);
  assign w_nxt_fetch = (w_nxt == S_W_FETCH) || (w_nxt == S_A_FETCH) || (w_nxt == S_I_FETCH);
  assign w_timed     = (r_state == S_W_LOAD) || (r_state == S_W_SETTLE) ||
                       (r_state == S_EXEC) || (r_state == S_FLUSH);
  assign w_lim       = (r_state == S_W_FETCH) ? L_COL_M1 : w_n_m1;
  // Bases come straight from the ports on the IDLE->fetch edge, before the latch lands.
  assign w_w_src     = (r_state == S_IDLE) ? w_base : r_w_base;
  assign w_a_src     = (r_state == S_IDLE) ? a_base : r_a_base;
  assign w_issue     = (w_nxt == S_ACC) && ofifo_valid && !r_iss_all;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start) w_nxt = (num_vec == '0) ? S_DONE : (mode_sel ? S_A_FETCH : S_W_FETCH);
      S_W_FETCH:  if (r_xmem_cen) w_nxt = S_W_LOAD;
      S_W_LOAD:   if (r_cnt == L_COL_M1) w_nxt = S_W_SETTLE;
      S_W_SETTLE: if (r_cnt == L_RC_M1) w_nxt = S_A_FETCH;
      S_A_FETCH:  if (r_xmem_cen) w_nxt = r_mode ? S_I_FETCH : S_EXEC;
      S_I_FETCH:  if (r_xmem_cen) w_nxt = S_EXEC;
      S_EXEC:     if (r_cnt == w_n_m1) w_nxt = r_mode ? S_FLUSH : S_DRAIN;
      S_FLUSH:    if (r_cnt == L_RC_M1) w_nxt = S_DRAIN;
      S_DRAIN:    if (ofifo_valid) w_nxt = S_ACC;
      S_ACC:      if (r_pmem_wr && (r_wcnt == w_n_m1)) w_nxt = S_DONE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;    r_cnt <= '0;       r_num <= '0;       r_mode <= 1'b0;
      r_acc <= 1'b0;        r_w_base <= '0;    r_a_base <= '0;    r_p_base <= '0;
      r_xmem_cen <= 1'b1;   r_xmem_addr <= '0; r_l0_wr <= 1'b0;   r_ififo_wr <= 1'b0;
      r_l0_rd <= 1'b0;      r_ififo_rd <= 1'b0; r_inst <= '0;     r_busy <= 1'b0;
      r_done <= 1'b0;       r_pmem_rd <= 1'b0; r_rd_addr <= '0;   r_v0 <= 1'b0;
      r_ofifo_rd <= 1'b0;   r_sfp <= 1'b0;     r_a1 <= '0;        r_pmem_wr <= 1'b0;
      r_wr_addr <= '0;      r_icnt <= '0;      r_wcnt <= '0;      r_iss_all <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && start) begin
        r_mode <= mode_sel;  r_acc <= acc_sel;   r_num <= num_vec;
        r_w_base <= w_base;  r_a_base <= a_base; r_p_base <= p_base;
      end

      if (w_nxt != r_state) r_cnt <= '0;
      else if (w_fetch) begin
        if (!r_xmem_cen && (r_cnt != w_lim)) r_cnt <= r_cnt + 1'b1;
      end else if (w_timed) r_cnt <= r_cnt + 1'b1;

      // Fetch: reads while cen=0, then one tail cycle for the delayed write of the last word.
      if (w_nxt_fetch && (w_nxt != r_state)) begin
        r_xmem_cen  <= 1'b0;
        r_xmem_addr <= (w_nxt == S_A_FETCH) ? w_a_src : w_w_src;
      end else if (w_fetch && !r_xmem_cen) begin
        if (r_cnt == w_lim) r_xmem_cen <= 1'b1;
        else r_xmem_addr <= r_xmem_addr + 1'b1;
      end else begin
        r_xmem_cen  <= 1'b1;
        r_xmem_addr <= '0;
      end
      r_l0_wr    <= !r_xmem_cen && ((r_state == S_W_FETCH) || (r_state == S_A_FETCH));
      r_ififo_wr <= !r_xmem_cen && (r_state == S_I_FETCH);

      r_l0_rd    <= (w_nxt == S_W_LOAD) || (w_nxt == S_EXEC);
      r_ififo_rd <= (w_nxt == S_EXEC) && r_mode;
      r_inst     <= f_inst(w_nxt, r_mode);
      r_busy     <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
      r_done     <= (w_nxt == S_DONE);

      // ACC pipe: stage 0 pmem read, stage 1 OFIFO pop + SFP, stage 2 pmem write.
      r_v0       <= w_issue;
      r_pmem_rd  <= w_issue && r_acc;
      r_rd_addr  <= w_issue ? (r_p_base + addr_w'(r_icnt)) : '0;
      r_ofifo_rd <= r_v0;
      r_sfp      <= r_v0 && r_acc;
      r_a1       <= r_v0 ? r_rd_addr : '0;
      r_pmem_wr  <= r_ofifo_rd;
      r_wr_addr  <= r_ofifo_rd ? r_a1 : '0;

      if (w_nxt == S_DONE) begin
        r_icnt <= '0;  r_wcnt <= '0;  r_iss_all <= 1'b0;
      end else begin
        if (w_issue) begin
          if (r_icnt == w_n_m1) r_iss_all <= 1'b1;
          else r_icnt <= r_icnt + 1'b1;
        end
        if (r_pmem_wr && (r_wcnt != w_n_m1)) r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign xmem_cen     = r_xmem_cen;
  assign xmem_addr    = r_xmem_addr;
  assign pmem_rd      = r_pmem_rd;
  assign pmem_rd_addr = r_rd_addr;
  assign pmem_wr      = r_pmem_wr;
  assign pmem_wr_addr = r_wr_addr;
  assign inst_w       = r_inst;
  assign l0_wr        = r_l0_wr;
  assign l0_rd        = r_l0_rd;
  assign ififo_wr     = r_ififo_wr;
  assign ififo_rd     = r_ififo_rd;
  assign sfp_acc_en   = r_sfp;
  assign ofifo_rd     = r_ofifo_rd;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: WS/OS tiles, ACC backpressure, reset abort and corner cases.
module tb_corelet_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, mode_sel, acc_sel, ofifo_valid;
  logic [7:0]  num_vec;
  logic [10:0] w_base, a_base, p_base;
  logic        busy, done, xmem_cen, pmem_rd, pmem_wr;
  logic [10:0] xmem_addr, pmem_rd_addr, pmem_wr_addr;
  logic [2:0]  inst_w;
  logic        l0_wr, l0_rd, ififo_wr, ififo_rd, sfp_acc_en, ofifo_rd;

  corelet_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mode_sel(mode_sel), .acc_sel(acc_sel),
    .num_vec(num_vec), .w_base(w_base), .a_base(a_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .busy(busy), .done(done), .xmem_cen(xmem_cen),
    .xmem_addr(xmem_addr), .pmem_rd(pmem_rd), .pmem_rd_addr(pmem_rd_addr),
    .pmem_wr(pmem_wr), .pmem_wr_addr(pmem_wr_addr), .inst_w(inst_w), .l0_wr(l0_wr),
    .l0_rd(l0_rd), .ififo_wr(ififo_wr), .ififo_rd(ififo_rd), .sfp_acc_en(sfp_acc_en),
    .ofifo_rd(ofifo_rd)
  );

  always #5 clk = ~clk;

  logic [46:0] w_idle;
  assign w_idle = {xmem_cen, busy, done, xmem_addr, pmem_rd, pmem_rd_addr, pmem_wr,
                   pmem_wr_addr, inst_w, l0_wr, l0_rd, ififo_wr, ififo_rd, sfp_acc_en, ofifo_rd};
  localparam logic [46:0] IDLE_VAL = {1'b1, 46'd0};

  int n_checks = 0;
  int n_fail   = 0;
  int done_cyc, ncyc;
  int lo0 = -1, lo1 = -1;

  logic [2:0]  t_inst[128];
  logic        t_cen[128], t_l0wr[128], t_ifwr[128], t_l0rd[128], t_ifrd[128];
  logic        t_ord[128], t_sfp[128], t_done[128], t_busy[128];
  logic [10:0] xr_a[$], rd_a[$], wr_a[$];
  int          rd_c[$], wr_c[$];

  function automatic logic ov_val(input int c);
    return !((c == lo0) || (c == lo1));
  endfunction

  // Runs one tile from IDLE; cycle 0 is the cycle in which start is presented.
  task automatic run_tile(input logic m, input logic acc, input logic [7:0] n,
                          input logic [10:0] wb, input logic [10:0] ab, input logic [10:0] pb,
                          input int hold);
    done_cyc = -1; ncyc = 0;
    xr_a.delete(); rd_a.delete(); wr_a.delete(); rd_c.delete(); wr_c.delete();
    @(posedge clk); #1;
    start = 1'b1; mode_sel = m; acc_sel = acc; num_vec = n;
    w_base = wb; a_base = ab; p_base = pb; ofifo_valid = ov_val(0);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      t_inst[c] = inst_w; t_cen[c] = xmem_cen; t_l0wr[c] = l0_wr; t_ifwr[c] = ififo_wr;
      t_l0rd[c] = l0_rd; t_ifrd[c] = ififo_rd; t_ord[c] = ofifo_rd; t_sfp[c] = sfp_acc_en;
      t_done[c] = done; t_busy[c] = busy;
      if (!xmem_cen) xr_a.push_back(xmem_addr);
      if (pmem_rd) begin rd_c.push_back(c); rd_a.push_back(pmem_rd_addr); end
      if (pmem_wr) begin wr_c.push_back(c); wr_a.push_back(pmem_wr_addr); end
      if (done && done_cyc < 0) done_cyc = c;
      ncyc = c + 1;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(posedge clk); #1;
      if (c + 1 >= hold) start = 1'b0;
      ofifo_valid = ov_val(c + 1);
    end
    start = 1'b0;
    n_checks++;
    if (done_cyc < 0) begin
      n_fail++; $display("FAIL tile_timeout: no done pulse within 120 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mode_sel = 1'b0; acc_sel = 1'b0; num_vec = '0;
    w_base = '0; a_base = '0; p_base = '0; ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (w_idle !== IDLE_VAL) begin n_fail++; $display("FAIL por_idle: got %0h want %0h", w_idle, IDLE_VAL); end
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_idle !== IDLE_VAL) begin n_fail++; $display("FAIL release_idle: got %0h want %0h", w_idle, IDLE_VAL); end
    // WS tile N=4, aborted in EXEC (cycles 39..42).
    @(posedge clk); #1;
    start = 1'b1; num_vec = 8'd4; w_base = 11'h010; a_base = 11'h040; p_base = 11'h100; acc_sel = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, inst_w} !== 4'b1010) begin n_fail++; $display("FAIL mid_exec: busy/inst got %0h want a", {busy, inst_w}); end
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (w_idle !== IDLE_VAL) begin n_fail++; $display("FAIL abort_idle: got %0h want %0h", w_idle, IDLE_VAL); end
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (w_idle !== IDLE_VAL) begin n_fail++; $display("FAIL post_abort_%0d: got %0h want %0h", i, w_idle, IDLE_VAL); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ws();
    int k001, f001, k010;
    logic [10:0] e;
    run_tile(1'b0, 1'b1, 8'd4, 11'h010, 11'h040, 11'h100, 1);
    n_checks++;
    if (xr_a.size() != 12) begin n_fail++; $display("FAIL ws_nreads: got %0d want 12", xr_a.size()); end
    for (int i = 0; i < 12; i++) begin
      e = (i < 8) ? 11'(11'h010 + i) : 11'(11'h040 + i - 8);
      n_checks++;
      if (i >= xr_a.size() || xr_a[i] !== e) begin
        n_fail++; $display("FAIL ws_xaddr_%0d: got %0h want %0h", i, (i < xr_a.size()) ? xr_a[i] : 11'h7ff, e);
      end
    end
    k001 = 0; f001 = -1; k010 = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (t_inst[c] == 3'b001 && t_l0rd[c]) begin k001++; if (f001 < 0) f001 = c; end
      if (t_inst[c] == 3'b010 && t_l0rd[c]) k010++;
    end
    n_checks++;
    if (k001 != 8 || f001 != 10) begin n_fail++; $display("FAIL ws_load: got %0d@%0d want 8@10", k001, f001); end
    n_checks++;
    if ({t_inst[33], t_cen[33], t_cen[34]} !== 5'b00010) begin
      n_fail++; $display("FAIL ws_settle: act fetch start got %b want 00010", {t_inst[33], t_cen[33], t_cen[34]});
    end
    n_checks++;
    if (k010 != 4 || t_inst[39] !== 3'b010) begin n_fail++; $display("FAIL ws_exec: got %0d want 4", k010); end
    n_checks++;
    if (rd_c.size() != 4 || wr_c.size() != 4 || rd_c[0] != 44) begin
      n_fail++; $display("FAIL ws_pmem_count: rd %0d wr %0d want 4 4", rd_c.size(), wr_c.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if ({rd_a[i], wr_a[i], 8'(wr_c[i] - rd_c[i])} !== {11'(11'h100 + i), 11'(11'h100 + i), 8'd2}) begin
          n_fail++; $display("FAIL ws_pmem_%0d: rd %0h wr %0h lag %0d want %0h %0h 2", i, rd_a[i], wr_a[i],
                             wr_c[i] - rd_c[i], 11'h100 + i, 11'h100 + i);
        end
      end
    end
    n_checks++;
    if (done_cyc != 50 || {t_busy[49], t_busy[50], t_done[51], t_busy[51]} !== 4'b1000) begin
      n_fail++; $display("FAIL ws_done: got %0d busy/done %b want 50 1000", done_cyc,
                         {t_busy[49], t_busy[50], t_done[51], t_busy[51]});
    end
  endtask

  task automatic test_os();
    int kl, kf, kb, kx, kfl, lastl, firstf;
    logic [10:0] exp_a[6];
    exp_a = '{11'h060, 11'h061, 11'h062, 11'h020, 11'h021, 11'h022};
    run_tile(1'b1, 1'b1, 8'd3, 11'h020, 11'h060, 11'h200, 1);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= xr_a.size() || xr_a[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL os_xaddr_%0d: got %0h want %0h", i, (i < xr_a.size()) ? xr_a[i] : 11'h7ff, exp_a[i]);
      end
    end
    kl = 0; kf = 0; kb = 0; kx = 0; kfl = 0; lastl = -1; firstf = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (t_l0wr[c]) begin kl++; lastl = c; end
      if (t_ifwr[c]) begin kf++; if (firstf < 0) firstf = c; end
      if (t_l0wr[c] && t_ifwr[c]) kb++;
      if (t_inst[c] == 3'b110 && t_l0rd[c] && t_ifrd[c]) kx++;
      if (t_inst[c] == 3'b101) kfl++;
    end
    n_checks++;
    if (kl != 3 || kf != 3 || kb != 0 || lastl >= firstf) begin
      n_fail++; $display("FAIL os_writes: l0 %0d ififo %0d both %0d want 3 3 0 ordered", kl, kf, kb);
    end
    n_checks++;
    if (kx != 3 || t_inst[9] !== 3'b110) begin n_fail++; $display("FAIL os_exec: got %0d want 3", kx); end
    n_checks++;
    if (kfl != 16 || t_inst[12] !== 3'b101) begin n_fail++; $display("FAIL os_flush: got %0d want 16", kfl); end
    n_checks++;
    if (done_cyc != 34) begin n_fail++; $display("FAIL os_done: got %0d want 34", done_cyc); end
  endtask

  task automatic test_backpressure();
    int erc[4], ewc[4];
    erc = '{44, 47, 48, 49};
    ewc = '{46, 49, 50, 51};
    lo0 = 44; lo1 = 45;
    run_tile(1'b0, 1'b1, 8'd4, 11'h010, 11'h040, 11'h100, 1);
    lo0 = -1; lo1 = -1;
    n_checks++;
    if (rd_c.size() != 4 || wr_c.size() != 4) begin
      n_fail++; $display("FAIL bp_count: rd %0d wr %0d want 4 4", rd_c.size(), wr_c.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rd_c[i] != erc[i] || wr_c[i] != ewc[i] || wr_a[i] !== 11'(11'h100 + i)) begin
          n_fail++; $display("FAIL bp_%0d: rd@%0d wr@%0d addr %0h want %0d %0d %0h", i, rd_c[i], wr_c[i],
                             wr_a[i], erc[i], ewc[i], 11'h100 + i);
        end
      end
    end
    n_checks++;
    if (done_cyc != 52) begin n_fail++; $display("FAIL bp_done: got %0d want 52", done_cyc); end
  endtask

  task automatic test_n0();
    int kb, kw;
    run_tile(1'b0, 1'b1, 8'd0, 11'h010, 11'h040, 11'h100, 1);
    kb = 0; kw = 0;
    for (int c = 0; c < ncyc; c++) begin kb += int'(t_busy[c]); kw += int'(t_l0wr[c]) + int'(t_ord[c]); end
    n_checks++;
    if (done_cyc != 1 || xr_a.size() != 0 || kb != 0 || kw != 0) begin
      n_fail++; $display("FAIL n0: done@%0d reads %0d busy %0d strobes %0d want 1 0 0 0", done_cyc, xr_a.size(), kb, kw);
    end
  endtask

  task automatic test_wrap();
    logic [10:0] e[4];
    e = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    run_tile(1'b0, 1'b1, 8'd4, 11'h010, 11'h040, 11'h7FE, 1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= wr_a.size() || wr_a[i] !== e[i]) begin
        n_fail++; $display("FAIL wrap_%0d: got %0h want %0h", i, (i < wr_a.size()) ? wr_a[i] : 11'h3ff, e[i]);
      end
    end
  endtask

  task automatic test_start_held();
    int kd;
    run_tile(1'b0, 1'b1, 8'd1, 11'h010, 11'h040, 11'h100, 42);
    kd = 0;
    for (int c = 0; c < ncyc; c++) kd += int'(t_done[c]);
    n_checks++;
    if (done_cyc != 41 || kd != 1 || {t_busy[42], t_busy[43]} !== 2'b00) begin
      n_fail++; $display("FAIL start_held: done@%0d pulses %0d busy %b want 41 1 00", done_cyc, kd,
                         {t_busy[42], t_busy[43]});
    end
  endtask

  task automatic test_acc_off();
    int ks, ko;
    run_tile(1'b0, 1'b0, 8'd2, 11'h010, 11'h040, 11'h300, 1);
    ks = 0; ko = 0;
    for (int c = 0; c < ncyc; c++) begin ks += int'(t_sfp[c]); ko += int'(t_ord[c]); end
    n_checks++;
    if (rd_c.size() != 0 || ks != 0 || ko != 2) begin
      n_fail++; $display("FAIL acc_off_strobes: pmem_rd %0d sfp %0d ofifo_rd %0d want 0 0 2", rd_c.size(), ks, ko);
    end
    n_checks++;
    if (wr_a.size() != 2 || wr_a[0] !== 11'h300 || wr_a[1] !== 11'h301 || done_cyc != 44) begin
      n_fail++; $display("FAIL acc_off_wr: writes %0d done@%0d want 2 (300,301) 44", wr_a.size(), done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_ws();
    test_os();
    test_backpressure();
    test_n0();
    test_wrap();
    test_start_held();
    test_acc_off();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
